// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter that shares the single external bus between the fetch
// port and the load/store port, one ExternalDrive transaction at a time.
module ext_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_data,
    output logic          fetch_valid,
    input  logic          data_req,
    input  logic          data_we,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_valid,
    output logic [AW-1:0] ext_addr,
    output logic [DW-1:0] ext_wdata,
    output logic          ext_oe,
    input  logic [DW-1:0] ext_rdata,
    output logic [2:0]    ext_drive,
    input  logic          ext_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] DRV_IDLE  = 3'b000;
    localparam logic [2:0] DRV_FETCH = 3'b001;
    localparam logic [2:0] DRV_READ  = 3'b010;
    localparam logic [2:0] DRV_WRITE = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RELEASE
    } busStateT;

    busStateT state;
    busStateT stateNext;

    logic          grantData;      // 1 = load/store port owns the bus
    logic          grantWe;
    logic          lastGrantData;
    logic [CW-1:0] waitCnt;

    logic          grantNow;
    logic          grantDataNext;
    logic          xferDone;
    logic          xferAbort;
    logic [2:0]    grantCmd;

    logic [AW-1:0] addrReg;
    logic [DW-1:0] wdataReg;
    logic [DW-1:0] fetchDataReg;
    logic [DW-1:0] dataRdataReg;
    logic          fetchValidReg;
    logic          dataValidReg;
    logic          timeoutReg;

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        stateNext     = state;
        grantNow      = 1'b0;
        grantDataNext = grantData;
        xferDone      = 1'b0;
        xferAbort     = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || data_req) begin
                    grantNow      = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    grantDataNext = data_req && (!fetch_req || !lastGrantData);
                    stateNext     = REQ;
                end
            end
            REQ: begin
                if (ext_ready) begin
                    xferDone  = 1'b1;
                    stateNext = RELEASE;
                end else if (waitCnt >= CW'(TIMEOUT - 1)) begin
                    xferAbort = 1'b1;
                    stateNext = RELEASE;
                end
            end
            RELEASE: begin
                if (!ext_ready) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grantData     <= 1'b0;
            grantWe       <= 1'b0;
            lastGrantData <= 1'b0;
            waitCnt       <= '0;
            addrReg       <= '0;
            wdataReg      <= '0;
            fetchDataReg  <= '0;
            dataRdataReg  <= '0;
            fetchValidReg <= 1'b0;
            dataValidReg  <= 1'b0;
            timeoutReg    <= 1'b0;
        end else begin
            fetchValidReg <= 1'b0;
            dataValidReg  <= 1'b0;
            timeoutReg    <= 1'b0;

            if (grantNow) begin
                grantData <= grantDataNext;
                grantWe   <= grantDataNext && data_we;
                addrReg   <= grantDataNext ? data_addr : fetch_addr;
                waitCnt   <= '0;
                if (grantDataNext && data_we) begin
                    wdataReg <= data_wdata;
                end
            end else if (state == REQ && !ext_ready && waitCnt != CW'(TIMEOUT)) begin
                waitCnt <= waitCnt + CW'(1);
            end

            // A timed-out read reports zero; a write never touches the read data.
            if (xferDone || xferAbort) begin
                lastGrantData <= grantData;
                timeoutReg    <= xferAbort;
                if (grantData) begin
                    dataValidReg <= 1'b1;
                    if (!grantWe) begin
                        dataRdataReg <= xferDone ? ext_rdata : '0;
                    end
                end else begin
                    fetchValidReg <= 1'b1;
                    fetchDataReg  <= xferDone ? ext_rdata : '0;
                end
            end
        end
    end

    always_comb begin
        grantCmd = DRV_FETCH;
        if (grantData) begin
            grantCmd = grantWe ? DRV_WRITE : DRV_READ;
        end
    end

    // The command is gated by rst so a reset mid-transfer releases the bus immediately.
    always_comb begin
        ext_drive = DRV_IDLE;
        ext_oe    = 1'b0;
        if (state == REQ && !rst) begin
            ext_drive = grantCmd;
            ext_oe    = grantWe;
        end
    end

    assign ext_addr    = addrReg;
    assign ext_wdata   = wdataReg;
    assign fetch_data  = fetchDataReg;
    assign data_rdata  = dataRdataReg;
    assign fetch_valid = fetchValidReg;
    assign data_valid  = dataValidReg;
    assign timeout_err = timeoutReg;
    assign busy        = (state != IDLE);

endmodule
